// File: rtl/converge_pkg.sv
// Shared types and elaboration helpers for the off-diagonal convergence checker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package converge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Accumulator width: full signed square plus enough headroom for every element.
    function automatic int acc_width(input int width, input int n_stocks);
        return 2 * width + $clog2(n_stocks * n_stocks);
    endfunction

    function automatic int num_beats(input int n_stocks, input int lanes);
        return (n_stocks * n_stocks) / lanes;
    endfunction

    localparam int DEF_N_STOCKS = 4;
    localparam int DEF_LANES    = 1;
    localparam int BEATS        = num_beats(DEF_N_STOCKS, DEF_LANES);

endpackage

// File: rtl/offdiag_sq_lane.sv
// One lane: square of a signed element, forced to zero when it sits on the diagonal.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module offdiag_sq_lane #(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4,
    parameter int IDX_W    = 5
) (
    input  logic [WIDTH-1:0]   elem_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [2*WIDTH-1:0] sq_o
);

    logic signed [2*WIDTH-1:0] ext;
    logic signed [2*WIDTH-1:0] prod;
    logic                      off_diag;

    // Sign-extend before multiplying so the most-negative value squares to +2^(2W-2).
    always_comb begin
        ext      = {{WIDTH{elem_i[WIDTH-1]}}, elem_i};
        prod     = ext * ext;
        off_diag = ((int'(idx_i) / N_STOCKS) != (int'(idx_i) % N_STOCKS));
        sq_o     = off_diag ? prod : '0;
    end

endmodule

// File: rtl/converge_stream.sv
// Streams a row-major matrix, sums off-diagonal squares, compares to 2^T, tracks non-converged sweeps.
// Latency: done_out two cycles after the final beat is presented (one FINAL cycle, then registered result).
// Backpressure: ready_out high only while accumulating; beats are held off in IDLE and FINAL.
module converge_stream
    import converge_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int FRACT    = 8,
    parameter  int N_STOCKS = DEF_N_STOCKS,
    parameter  int LANES    = DEF_LANES,
    parameter  int MAX_ITER = 32,
    parameter  int TH_W     = 6,
    localparam int ACC_W    = acc_width(WIDTH, N_STOCKS),
    localparam int IT_W     = $clog2(MAX_ITER + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   clear_in,
    input  logic [TH_W-1:0]        threshold_in,
    input  logic                   valid_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   ready_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   conv_out,
    output logic                   timeout_out,
    output logic [ACC_W-1:0]       sum_out,
    output logic [IT_W-1:0]        iter_count_out
);

    localparam int BEATS_L = num_beats(N_STOCKS, LANES);
    localparam int BEAT_W  = $clog2(BEATS_L + 1);
    localparam int IDX_W   = $clog2(N_STOCKS * N_STOCKS + 1);

    if (N_STOCKS % LANES != 0) begin : g_lanes_chk
        $error("converge_stream: LANES must divide N_STOCKS");
    end

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [TH_W-1:0]    thr_q, thr_d;
    logic               conv_q, conv_d;
    logic               done_q, done_d;
    logic               to_q, to_d;
    logic [IT_W-1:0]    iter_q, iter_d;

    logic [2*WIDTH-1:0] lane_sq [LANES];
    logic [ACC_W-1:0]   beat_sum;
    logic               accept;
    logic               conv_now;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] lane_idx;
        assign lane_idx = IDX_W'(int'(beat_q) * LANES + k);

        offdiag_sq_lane #(
            .WIDTH    (WIDTH),
            .N_STOCKS (N_STOCKS),
            .IDX_W    (IDX_W)
        ) u_lane (
            .elem_i (data_in[k*WIDTH +: WIDTH]),
            .idx_i  (lane_idx),
            .sq_o   (lane_sq[k])
        );
    end

    // Sum all lane contributions of the current beat in one cycle.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + ACC_W'(lane_sq[k]);
        end
    end

    // The sum is never negative, so x>>>FRACT < 2^T reduces to (x>>FRACT)>>T being zero;
    // large T shifts everything out and naturally reports converged.
    assign conv_now = (((acc_q >> FRACT) >> thr_q) == '0);
    assign accept   = valid_in && (state_q == ACCUM);

    // Next-state, datapath and iteration-tracking logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        beat_d  = beat_q;
        thr_d   = thr_q;
        conv_d  = conv_q;
        done_d  = 1'b0;
        iter_d  = iter_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    thr_d   = threshold_in;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d  = acc_q + beat_sum;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS_L - 1)) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                sum_d  = acc_q;
                conv_d = conv_now;
                done_d = 1'b1;
                if (conv_now) begin
                    iter_d = '0;
                end else if (iter_q != IT_W'(MAX_ITER)) begin
                    iter_d = iter_q + 1'b1;
                end
                to_d    = to_q | (!conv_now && (iter_d == IT_W'(MAX_ITER)));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides any same-cycle iteration update but leaves the check running.
        if (clear_in) begin
            iter_d = '0;
            to_d   = 1'b0;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            beat_q  <= '0;
            thr_q   <= '0;
            conv_q  <= 1'b0;
            done_q  <= 1'b0;
            iter_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            beat_q  <= beat_d;
            thr_q   <= thr_d;
            conv_q  <= conv_d;
            done_q  <= done_d;
            iter_q  <= iter_d;
            to_q    <= to_d;
        end
    end

    assign ready_out      = (state_q == ACCUM);
    assign busy_out       = (state_q == ACCUM) || (state_q == FINAL);
    assign done_out       = done_q;
    assign conv_out       = conv_q;
    assign timeout_out    = to_q;
    assign sum_out        = sum_q;
    assign iter_count_out = iter_q;

endmodule
